// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path (and a future transmitter).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Clocks per oversample tick; users guard the result against values below 1.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return clk_hz / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("uart_baud_tick: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end

  logic [CW-1:0] cnt;

  // Wrap the divider at DIV-1; the wrap cycle is the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cnt <= '0;
    else if (cnt == TC) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == TC);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-vote bit decisions and a valid/ready output.
// Build option: define UART_RX_FIFO_EN to replace the single output register with a
// FIFO_DEPTH-entry show-ahead FIFO.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun_err
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int EW = DATA_BITS + 3;
  localparam logic [SW-1:0] SMP_A    = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] SMP_B    = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] SMP_DEC  = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY > PARITY_EVEN || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_rx_ovs: parameter out of range");
  end

  logic                 sync_q1, sync_q2, rx_s;
  logic                 tick;
  rx_state_t            state, state_next;
  logic [SW-1:0]        s_cnt;
  logic                 smp_a, smp_b;
  logic [3:0]           bits_left;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, ferr_acc, any_one;
  logic                 decide, bit_end, bit_val;
  logic                 commit, c_frame, c_parity, c_break;
  logic [EW-1:0]        entry;

  // Two-flop synchroniser, parked at the idle level while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= rx_line;
      sync_q2 <= sync_q1;
    end
  end
  assign rx_s = sync_q2;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign decide  = tick && (s_cnt == SMP_DEC);
  assign bit_end = tick && (s_cnt == SMP_LAST);
  assign bit_val = maj3(smp_a, smp_b, rx_s);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next state; the last stop bit commits on its decision tick, not at bit end.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (tick && !rx_s) state_next = ST_START;
      ST_START:    if (decide && bit_val) state_next = ST_IDLE;
                   else if (bit_end)      state_next = ST_DATA;
      ST_DATA:     if (bit_end && bits_left == '0)
                     state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:   if (bit_end) state_next = ST_STOP;
      ST_STOP:     if (commit) state_next = c_break ? ST_BRK_WAIT : ST_IDLE;
      ST_BRK_WAIT: if (rx_s) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // FSM outputs and the frame status formed at commit time.
  always_comb begin
    rx_busy  = (state != ST_IDLE);
    commit   = (state == ST_STOP) && decide && (bits_left == '0);
    c_frame  = ferr_acc | ~bit_val;
    c_break  = ~(any_one | bit_val);
    c_parity = 1'b0;
    case (PARITY)
      PARITY_ODD:  c_parity = ~(^shreg ^ par_bit);
      PARITY_EVEN: c_parity = ^shreg ^ par_bit;
      default:     c_parity = 1'b0;
    endcase
  end

  assign entry = {shreg, c_frame, c_parity, c_break};

  // Bit timing, sampling, shifting and per-frame error accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_cnt     <= '0;
      smp_a     <= 1'b1;
      smp_b     <= 1'b1;
      bits_left <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      ferr_acc  <= 1'b0;
      any_one   <= 1'b0;
    end else begin
      if (state == ST_IDLE || state == ST_BRK_WAIT) s_cnt <= '0;
      else if (tick) s_cnt <= (s_cnt == SMP_LAST) ? '0 : s_cnt + 1'b1;

      if (tick && s_cnt == SMP_A) smp_a <= rx_s;
      if (tick && s_cnt == SMP_B) smp_b <= rx_s;

      if (state == ST_IDLE) begin
        ferr_acc <= 1'b0;
        any_one  <= 1'b0;
      end

      if (decide) begin
        case (state)
          ST_DATA: begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            any_one <= any_one | bit_val;
          end
          ST_PARITY: begin
            par_bit <= bit_val;
            any_one <= any_one | bit_val;
          end
          ST_STOP: begin
            ferr_acc <= ferr_acc | ~bit_val;
            any_one  <= any_one | bit_val;
          end
          default: ;
        endcase
      end

      if (bit_end) begin
        case (state)
          ST_START:  bits_left <= DATA_LAST;
          ST_DATA:   bits_left <= (bits_left == '0) ? STOP_LAST : bits_left - 1'b1;
          ST_PARITY: bits_left <= STOP_LAST;
          ST_STOP:   bits_left <= bits_left - 1'b1;
          default:   ;
        endcase
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, push, pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rx_valid = ~empty;
  assign pop      = rx_valid && rx_ready;
  // A pop in the same clk frees the head slot, so a full FIFO still accepts.
  assign push     = commit && (~full || pop);
  assign {rx_data, frame_err, parity_err, break_det} = mem[rptr[AW-1:0]];

  // FIFO storage and pointers; overrun flags a commit that could not be stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr        <= '0;
      rptr        <= '0;
      overrun_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= entry;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      overrun_err <= commit && ~push;
    end
  end
`else
  logic [EW-1:0] out_q;

  assign {rx_data, frame_err, parity_err, break_det} = out_q;

  // Single output register; a commit lands if the slot is empty or being consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= commit && rx_valid && ~rx_ready;
      if (commit && (~rx_valid || rx_ready)) begin
        out_q    <= entry;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: 8N1, 8E1 and 7O2 instances at 16 clk per bit.
module tb_uart_rx_ovs;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic l0 = 1'b1, l1 = 1'b1, l2 = 1'b1;
  logic r0 = 1'b1, r1 = 1'b1, r2 = 1'b1;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, v1, v2, b0, b1, b2, fe0, fe1, fe2, pe0, pe1, pe2, bd0, bd1, bd2, ov0, ov1, ov2;

  int checks = 0;
  int errors = 0;
  logic [10:0] q0[$], q1[$], q2[$];
  int vcyc0 = 0, novr0 = 0, novr1 = 0, novr2 = 0;

  uart_rx_ovs #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_8n1 (
    .clk(clk), .reset(reset), .rx_line(l0), .rx_data(d0), .rx_valid(v0), .rx_ready(r0),
    .rx_busy(b0), .frame_err(fe0), .parity_err(pe0), .break_det(bd0), .overrun_err(ov0));

  uart_rx_ovs #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) u_8e1 (
    .clk(clk), .reset(reset), .rx_line(l1), .rx_data(d1), .rx_valid(v1), .rx_ready(r1),
    .rx_busy(b1), .frame_err(fe1), .parity_err(pe1), .break_det(bd1), .overrun_err(ov1));

  uart_rx_ovs #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u_7o2 (
    .clk(clk), .reset(reset), .rx_line(l2), .rx_data(d2), .rx_valid(v2), .rx_ready(r2),
    .rx_busy(b2), .frame_err(fe2), .parity_err(pe2), .break_det(bd2), .overrun_err(ov2));

  // Record every handshaked frame as {break, parity, frame, data} and count overrun pulses.
  always @(negedge clk) begin
    if (v0) vcyc0 <= vcyc0 + 1;
    if (v0 && r0) q0.push_back({bd0, pe0, fe0, d0});
    if (v1 && r1) q1.push_back({bd1, pe1, fe1, d1});
    if (v2 && r2) q2.push_back({bd2, pe2, fe2, 1'b0, d2});
    if (ov0) novr0 <= novr0 + 1;
    if (ov1) novr1 <= novr1 + 1;
    if (ov2) novr2 <= novr2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       l0 = v;
      1:       l1 = v;
      default: l2 = v;
    endcase
  endtask

  // Drive a level for n clks; entered and left just after a rising edge.
  task automatic hold(input int sel, input logic v, input int n);
    set_line(sel, v);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits[0] is the start bit; one bit may carry a 1-clk inverted spike at its centre.
  task automatic send_frame(input int sel, input logic [15:0] bits, input int nbits, input int spike);
    for (int i = 0; i < nbits; i++) begin
      if (i == spike) begin
        hold(sel, bits[i], 8);
        hold(sel, ~bits[i], 1);
        hold(sel, bits[i], 7);
      end else begin
        hold(sel, bits[i], 16);
      end
    end
    hold(sel, 1'b1, 16);
  endtask

  initial begin
    int n, c, o;
    logic [15:0] fb;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", v0, 0);
    check("rst_busy", b0, 0);
    check("rst_data", d0, 0);
    check("rst_overrun", ov0, 0);
    reset = 1'b0;
    hold(0, 1'b1, 20);

    // 8N1 0xA5 with ready held high
    n = q0.size(); c = vcyc0;
    send_frame(0, 16'h034A, 10, -1);
    check("8n1_count", q0.size() - n, 1);
    check("8n1_a5_entry", q0[n], 11'h0A5);
    check("8n1_valid_cycles", vcyc0 - c, 1);
    check("8n1_busy_after", b0, 0);

    // 8E1 0x03: parity bit 1 is wrong for even parity, parity bit 0 is right
    n = q1.size();
    send_frame(1, 16'h0606, 11, -1);
    send_frame(1, 16'h0406, 11, -1);
    check("8e1_count", q1.size() - n, 2);
    check("8e1_bad_parity", q1[n], 11'h203);
    check("8e1_good_parity", q1[n+1], 11'h003);
    check("8e1_overrun", novr1, 0);
    check("8e1_busy_after", b1, 0);

    // 7O2 0x55, correct odd parity, second stop bit 0
    n = q2.size();
    send_frame(2, 16'h03AA, 11, -1);
    hold(2, 1'b1, 32);
    check("7o2_count", q2.size() - n, 1);
    check("7o2_frame_err", q2[n], 11'h155);
    check("7o2_overrun", novr2, 0);
    check("7o2_busy_after", b2, 0);

    // 6-clk glitch is a false start
    n = q0.size();
    hold(0, 1'b0, 4);
    check("glitch_busy_rise", b0, 1);
    hold(0, 1'b0, 2);
    hold(0, 1'b1, 16);
    check("glitch_busy_drop", b0, 0);
    hold(0, 1'b1, 16);
    check("glitch_no_frame", q0.size() - n, 0);

    // Single-clk spike in the middle of data bit 3 of 0x00 is outvoted
    n = q0.size();
    send_frame(0, 16'h0200, 10, 4);
    check("spike_count", q0.size() - n, 1);
    check("spike_entry", q0[n], 11'h000);

    // Line low for three frame times: one break frame, then nothing until high
    n = q0.size();
    hold(0, 1'b0, 480);
    check("break_count", q0.size() - n, 1);
    check("break_entry", q0[n], 11'h500);
    check("break_busy_wait", b0, 1);
    hold(0, 1'b1, 48);
    check("break_no_more", q0.size() - n, 1);
    check("break_busy_drop", b0, 0);

`ifndef UART_RX_FIFO_EN
    // Consumer stalled: 0x11 held, 0x22 dropped with one overrun pulse
    r0 = 1'b0;
    n = q0.size(); o = novr0;
    send_frame(0, 16'h0222, 10, -1);
    check("ovr_first_valid", v0, 1);
    check("ovr_first_data", d0, 8'h11);
    send_frame(0, 16'h0244, 10, -1);
    check("ovr_pulses", novr0 - o, 1);
    check("ovr_held_valid", v0, 1);
    check("ovr_held_data", d0, 8'h11);
    r0 = 1'b1;
    hold(0, 1'b1, 4);
    check("ovr_drain_count", q0.size() - n, 1);
    check("ovr_drain_entry", q0[n], 11'h011);
    check("ovr_valid_clear", v0, 0);
`else
    // Consumer stalled: nine frames into an 8-deep FIFO, one overrun
    r0 = 1'b0;
    n = q0.size(); o = novr0;
    for (int i = 0; i < 9; i++) begin
      fb = 16'h0200 | (16'(8'h10 + i) << 1);
      send_frame(0, fb, 10, -1);
    end
    check("fifo_ovr_pulses", novr0 - o, 1);
    check("fifo_head_valid", v0, 1);
    check("fifo_head_data", d0, 8'h10);
    r0 = 1'b1;
    hold(0, 1'b1, 12);
    check("fifo_drain_count", q0.size() - n, 8);
    for (int i = 0; i < 8; i++) check("fifo_order", q0[n+i], 32'h10 + i);
    check("fifo_valid_clear", v0, 0);
`endif

    // Reset in the middle of the data bits, then a clean 0x3C
    hold(0, 1'b0, 56);
    check("mid_busy", b0, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", v0, 0);
    check("mid_rst_busy", b0, 0);
    check("mid_rst_data", d0, 0);
    check("mid_rst_flags", {fe0, pe0, bd0}, 0);
    l0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    hold(0, 1'b1, 32);
    n = q0.size();
    send_frame(0, 16'h0278, 10, -1);
    check("post_rst_count", q0.size() - n, 1);
    check("post_rst_entry", q0[n], 11'h03C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
